// File: rtl/vout_frame_buffer_rd_ctrl.sv
// Read-side frame buffer controller: fetches a width x height window from DDR
// line by line as read bursts, buffers words in a local FIFO and streams them
// out with a valid/ready handshake plus start-of-frame / end-of-line marks.
`timescale 1ns/1ps

module vout_frame_buffer_rd_ctrl #(
    parameter int MEM_DATA_BITS = 64,
    parameter int BURST_LEN     = 128,
    parameter int FIFO_DEPTH    = 512
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic [7:0]               base_hsync,
    input  logic [11:0]              base_vsync,
    input  logic [11:0]              width,
    input  logic [11:0]              height,
    output logic                     rd_burst_req,
    output logic [9:0]               rd_burst_len,
    output logic [23:0]              rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     burst_finish,
    output logic [MEM_DATA_BITS-1:0] vout_data,
    output logic                     vout_valid,
    input  logic                     vout_ready,
    output logic                     vout_sof,
    output logic                     vout_eol,
    output logic                     frame_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;

    typedef enum logic [2:0] {
        IDLE,
        LINE_START,
        WAIT_SPACE,
        BURSTING,
        BURST_END,
        LINE_END,
        DRAIN
    } state_t;

    state_t                   state;
    logic [7:0]               hsync_q;
    logic [11:0]              line_q;
    logic [11:0]              width_q;
    logic [11:0]              lines_left;
    logic [11:0]              remain;
    logic [9:0]               reserved;

    logic [MEM_DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              fifo_count;

    logic [11:0]              out_col;
    logic [11:0]              out_row;

    logic [9:0]               burst_words;
    logic [CW-1:0]            space_avail;
    logic                     space_ok;
    logic                     push;
    logic                     pop;
    logic                     flush;
    logic                     last_burst;
    logic                     line_msb_unused;

    // The DDR address only carries 11 line bits; the line counter wraps through them.
    assign line_msb_unused = line_q[11];

    // Burst sizing and free-space check; reserved covers words still in flight.
    always_comb begin
        burst_words = 10'(BURST_LEN);
        if (remain <= 12'(BURST_LEN)) begin
            burst_words = remain[9:0];
        end
        space_avail = CW'(FIFO_DEPTH) - CW'(fifo_count) - CW'(reserved);
        space_ok    = (space_avail >= CW'(burst_words));
        last_burst  = (remain == {2'b00, rd_burst_len}) && (lines_left == 12'd1);
    end

    // Flush the FIFO on a restart, except mid-burst where it waits for burst_finish.
    always_comb begin
        flush = 1'b0;
        case (state)
            BURSTING: flush = frame_start && burst_finish;
            DRAIN:    flush = burst_finish;
            default:  flush = frame_start;
        endcase
    end

    assign push = rd_burst_data_valid && (state == BURSTING) && !frame_start;
    assign pop  = vout_valid && vout_ready;

    assign vout_valid = (fifo_count != '0);
    assign vout_data  = vout_valid ? fifo_mem[rd_ptr] : '0;
    assign vout_sof   = vout_valid && (out_col == 12'd0) && (out_row == 12'd0);
    assign vout_eol   = vout_valid && (out_col == (width_q - 12'd1));

    // Main fetch sequencer: line setup, space wait, burst issue and frame restart.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state         <= IDLE;
            hsync_q       <= '0;
            line_q        <= '0;
            width_q       <= '0;
            lines_left    <= '0;
            remain        <= '0;
            reserved      <= '0;
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            rd_burst_addr <= '0;
            frame_busy    <= 1'b0;
        end else begin
            if (frame_start) begin
                hsync_q    <= base_hsync;
                line_q     <= base_vsync;
                width_q    <= width;
                lines_left <= height;
                frame_busy <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= LINE_START;
                    end
                end
                LINE_START: begin
                    if (!frame_start) begin
                        if ((width_q == '0) || (lines_left == '0)) begin
                            state      <= IDLE;
                            frame_busy <= 1'b0;
                        end else begin
                            rd_burst_addr <= {2'b00, line_q[10:0], 3'b000, hsync_q};
                            remain        <= width_q;
                            state         <= WAIT_SPACE;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (frame_start) begin
                        state <= LINE_START;
                    end else if (space_ok) begin
                        rd_burst_len <= burst_words;
                        rd_burst_req <= 1'b1;
                        reserved     <= burst_words;
                        state        <= BURSTING;
                    end
                end
                BURSTING: begin
                    if (rd_burst_data_valid || burst_finish) begin
                        rd_burst_req <= 1'b0;
                    end
                    if (rd_burst_data_valid && (reserved != '0)) begin
                        reserved <= reserved - 10'd1;
                    end
                    if (frame_start) begin
                        if (burst_finish) begin
                            reserved <= '0;
                            state    <= LINE_START;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (burst_finish) begin
                        reserved      <= '0;
                        remain        <= remain - {2'b00, rd_burst_len};
                        rd_burst_addr <= rd_burst_addr + 24'(BURST_LEN);
                        state         <= BURST_END;
                        if (last_burst) begin
                            frame_busy <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_burst_data_valid || burst_finish) begin
                        rd_burst_req <= 1'b0;
                    end
                    if (rd_burst_data_valid && (reserved != '0)) begin
                        reserved <= reserved - 10'd1;
                    end
                    if (burst_finish) begin
                        reserved <= '0;
                        state    <= LINE_START;
                    end
                end
                BURST_END: begin
                    if (frame_start) begin
                        state <= LINE_START;
                    end else if (remain == '0) begin
                        state <= LINE_END;
                    end else begin
                        state <= WAIT_SPACE;
                    end
                end
                LINE_END: begin
                    if (frame_start) begin
                        state <= LINE_START;
                    end else if (lines_left <= 12'd1) begin
                        lines_left <= '0;
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        lines_left <= lines_left - 12'd1;
                        line_q     <= line_q + 12'd1;
                        state      <= LINE_START;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage write port; contents need no reset since occupancy gates reads.
    always_ff @(posedge mem_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rd_burst_data;
        end
    end

    // FIFO pointers and occupancy, cleared by reset or a frame flush.
    always_ff @(posedge mem_clk) begin
        if (rst || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output-side column/row tracking that produces the sof and eol marks.
    always_ff @(posedge mem_clk) begin
        if (rst || flush || frame_start) begin
            out_col <= '0;
            out_row <= '0;
        end else if (pop) begin
            if (out_col == (width_q - 12'd1)) begin
                out_col <= '0;
                out_row <= out_row + 12'd1;
            end else begin
                out_col <= out_col + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_vout_frame_buffer_rd_ctrl.sv
// Self-checking bench for vout_frame_buffer_rd_ctrl: a memory-controller
// responder, a scoreboard of expected bursts and output words, table-driven
// frame vectors and hand-written stall / abort / empty-frame sequences.
`timescale 1ns/1ps

module tb_vout_frame_buffer_rd_ctrl;

    logic        mem_clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [7:0]  base_hsync;
    logic [11:0] base_vsync;
    logic [11:0] width;
    logic [11:0] height;
    logic        rd_burst_req;
    logic [9:0]  rd_burst_len;
    logic [23:0] rd_burst_addr;
    logic        rd_burst_data_valid;
    logic [63:0] rd_burst_data;
    logic        burst_finish;
    logic [63:0] vout_data;
    logic        vout_valid;
    logic        vout_ready;
    logic        vout_sof;
    logic        vout_eol;
    logic        frame_busy;

    vout_frame_buffer_rd_ctrl dut (
        .mem_clk             (mem_clk),
        .rst                 (rst),
        .frame_start         (frame_start),
        .base_hsync          (base_hsync),
        .base_vsync          (base_vsync),
        .width               (width),
        .height              (height),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .burst_finish        (burst_finish),
        .vout_data           (vout_data),
        .vout_valid          (vout_valid),
        .vout_ready          (vout_ready),
        .vout_sof            (vout_sof),
        .vout_eol            (vout_eol),
        .frame_busy          (frame_busy)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        logic [23:0] addr;
        int          len;
    } burst_t;

    typedef struct {
        logic [63:0] data;
        bit          sof;
        bit          eol;
    } word_t;

    typedef struct {
        logic [7:0]  hs;
        logic [11:0] vs;
        logic [11:0] w;
        logic [11:0] h;
        bit          fin_with_last;
        int          exp_bursts;
        int          exp_words;
        logic [23:0] exp_first_addr;
    } vec_t;

    burst_t      burst_q[$];
    word_t       word_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          words_sent = 0;
    int          bursts_seen = 0;
    int          words_out = 0;
    logic [23:0] first_addr = '0;
    bit          fin_last = 1'b0;
    int          ready_mode = 0;

    // Memory content seen by the controller: a pattern derived from the word address.
    function automatic logic [63:0] wordData(input logic [23:0] a);
        return {8'hC3, a, 8'h3C, a ^ 24'hFFFFFF};
    endfunction

    // Single comparison point: counts every check and reports misses.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model of a frame: expected bursts and expected output words.
    task automatic buildFrame(input logic [7:0] hs, input logic [11:0] vs, input logic [11:0] w, input logic [11:0] h);
        for (int l = 0; l < int'(h); l++) begin
            int line_no;
            int base;
            int rem;
            int off;
            line_no = (int'(vs) + l) % 2048;
            base    = line_no * 2048 + int'(hs);
            rem     = int'(w);
            off     = 0;
            while (rem > 0) begin
                int len;
                len = (rem > 128) ? 128 : rem;
                burst_q.push_back('{addr: 24'(base + off), len: len});
                off += 128;
                rem -= len;
            end
            for (int c = 0; c < int'(w); c++) begin
                word_q.push_back('{data: wordData(24'(base + c)), sof: (l == 0 && c == 0), eol: (c == int'(w) - 1)});
            end
        end
    endtask

    task automatic resetCounters();
        words_sent  = 0;
        bursts_seen = 0;
        words_out   = 0;
        first_addr  = '0;
    endtask

    // Load the model for a frame and pulse frame_start for one cycle.
    task automatic applyStimulus(input logic [7:0] hs, input logic [11:0] vs, input logic [11:0] w, input logic [11:0] h);
        buildFrame(hs, vs, w, h);
        @(negedge mem_clk);
        base_hsync  = hs;
        base_vsync  = vs;
        width       = w;
        height      = h;
        frame_start = 1'b1;
        @(negedge mem_clk);
        frame_start = 1'b0;
    endtask

    // Wait for the frame to be fetched and fully streamed, within a cycle budget.
    task automatic waitDone(input string name, input int bound);
        int cyc;
        cyc = 0;
        while ((word_q.size() != 0 || burst_q.size() != 0 || frame_busy) && cyc < bound) begin
            @(negedge mem_clk);
            #1;
            cyc++;
        end
        checkOutput(name, 64'(cyc < bound), 64'd1);
    endtask

    // Downstream ready: held low, held high, or random back-pressure.
    initial begin
        vout_ready = 1'b0;
        forever begin
            @(negedge mem_clk);
            case (ready_mode)
                0:       vout_ready = 1'b0;
                1:       vout_ready = 1'b1;
                default: vout_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Memory controller responder: accepts a request, checks it, returns the words.
    initial begin
        logic [23:0] b_addr;
        int          b_len;
        rd_burst_data_valid = 1'b0;
        rd_burst_data       = '0;
        burst_finish        = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (!rst && rd_burst_req) begin
                b_addr = rd_burst_addr;
                b_len  = int'(rd_burst_len);
                if (bursts_seen == 0) begin
                    first_addr = b_addr;
                end
                bursts_seen++;
                if (burst_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("[TB] FAIL unexpected burst: got addr %0h len %0d, expected none", b_addr, b_len);
                end else begin
                    burst_t eb;
                    eb = burst_q.pop_front();
                    checkOutput("burst addr", 64'(b_addr), 64'(eb.addr));
                    checkOutput("burst len", 64'(b_len), 64'(eb.len));
                end
                repeat (2) @(negedge mem_clk);
                for (int i = 0; i < b_len; i++) begin
                    rd_burst_data_valid = 1'b1;
                    rd_burst_data       = wordData(b_addr + 24'(i));
                    words_sent++;
                    if (fin_last && i == b_len - 1) begin
                        burst_finish = 1'b1;
                    end
                    @(negedge mem_clk);
                    rd_burst_data_valid = 1'b0;
                    burst_finish        = 1'b0;
                end
                if (!fin_last || b_len == 0) begin
                    burst_finish = 1'b1;
                    @(negedge mem_clk);
                    burst_finish = 1'b0;
                end
            end
        end
    end

    // Output monitor: every accepted word is popped from the scoreboard and compared.
    initial begin
        forever begin
            @(negedge mem_clk);
            #1;
            if (!rst && vout_valid && vout_ready) begin
                if (word_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("[TB] FAIL unexpected word: got %0h, expected none", vout_data);
                end else begin
                    word_t ew;
                    ew = word_q.pop_front();
                    checkOutput("word data", vout_data, ew.data);
                    checkOutput("word sof/eol", 64'({vout_sof, vout_eol}), 64'({ew.sof, ew.eol}));
                end
                words_out++;
            end
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        int   busy_cycles;
        int   cyc;

        vecs[0] = '{hs: 8'h00, vs: 12'd10,   w: 12'd256, h: 12'd2, fin_with_last: 1'b0,
                    exp_bursts: 4, exp_words: 512, exp_first_addr: 24'h005000};
        vecs[1] = '{hs: 8'h00, vs: 12'd3,    w: 12'd300, h: 12'd1, fin_with_last: 1'b0,
                    exp_bursts: 3, exp_words: 300, exp_first_addr: 24'h001800};
        vecs[2] = '{hs: 8'h20, vs: 12'd2047, w: 12'd16,  h: 12'd2, fin_with_last: 1'b1,
                    exp_bursts: 2, exp_words: 32,  exp_first_addr: 24'h3FF820};
        vecs[3] = '{hs: 8'h05, vs: 12'd100,  w: 12'd130, h: 12'd3, fin_with_last: 1'b1,
                    exp_bursts: 6, exp_words: 390, exp_first_addr: 24'h032005};

        rst         = 1'b1;
        frame_start = 1'b0;
        base_hsync  = '0;
        base_vsync  = '0;
        width       = '0;
        height      = '0;
        repeat (3) @(negedge mem_clk);
        #1;
        checkOutput("reset rd_burst_req", 64'(rd_burst_req), 64'd0);
        checkOutput("reset rd_burst_len", 64'(rd_burst_len), 64'd0);
        checkOutput("reset rd_burst_addr", 64'(rd_burst_addr), 64'd0);
        checkOutput("reset vout_valid", 64'(vout_valid), 64'd0);
        checkOutput("reset sof/eol", 64'({vout_sof, vout_eol}), 64'd0);
        checkOutput("reset frame_busy", 64'(frame_busy), 64'd0);
        checkOutput("reset vout_data", vout_data, 64'd0);
        @(negedge mem_clk);
        rst = 1'b0;
        repeat (2) @(negedge mem_clk);

        // Table-driven frames with continuous or random downstream ready.
        for (int i = 0; i < 4; i++) begin
            $display("[TB] frame vector %0d: w=%0d h=%0d vs=%0d hs=%0d", i, vecs[i].w, vecs[i].h, vecs[i].vs, vecs[i].hs);
            ready_mode = (i % 2 == 0) ? 1 : 2;
            fin_last   = vecs[i].fin_with_last;
            resetCounters();
            applyStimulus(vecs[i].hs, vecs[i].vs, vecs[i].w, vecs[i].h);
            waitDone("vector done", 20000);
            checkOutput("vector bursts", 64'(bursts_seen), 64'(vecs[i].exp_bursts));
            checkOutput("vector words out", 64'(words_out), 64'(vecs[i].exp_words));
            checkOutput("vector first addr", 64'(first_addr), 64'(vecs[i].exp_first_addr));
            checkOutput("vector idle valid", 64'(vout_valid), 64'd0);
            repeat (3) @(negedge mem_clk);
        end

        // Back-pressure: FIFO fills to capacity and fetch stalls with no request.
        $display("[TB] stall sequence");
        ready_mode = 0;
        fin_last   = 1'b0;
        resetCounters();
        applyStimulus(8'h00, 12'd500, 12'd1024, 12'd1);
        cyc = 0;
        while (words_sent < 512 && cyc < 5000) begin
            @(negedge mem_clk);
            cyc++;
        end
        repeat (100) @(negedge mem_clk);
        #1;
        checkOutput("stall words fetched", 64'(words_sent), 64'd512);
        checkOutput("stall bursts", 64'(bursts_seen), 64'd4);
        checkOutput("stall rd_burst_req", 64'(rd_burst_req), 64'd0);
        checkOutput("stall frame_busy", 64'(frame_busy), 64'd1);
        checkOutput("stall vout_valid", 64'(vout_valid), 64'd1);
        ready_mode = 1;
        waitDone("stall done", 20000);
        checkOutput("stall words out", 64'(words_out), 64'd1024);
        checkOutput("stall total bursts", 64'(bursts_seen), 64'd8);
        repeat (3) @(negedge mem_clk);

        // Restart in the middle of a burst: the rest of it is drained and dropped.
        $display("[TB] abort sequence");
        ready_mode = 0;
        fin_last   = 1'b0;
        resetCounters();
        applyStimulus(8'h00, 12'd20, 12'd256, 12'd1);
        cyc = 0;
        while (words_sent < 50 && cyc < 2000) begin
            @(negedge mem_clk);
            #2;
            cyc++;
        end
        checkOutput("abort old data buffered", 64'(vout_valid), 64'd1);
        word_q.delete();
        burst_q.delete();
        bursts_seen = 0;
        words_out   = 0;
        applyStimulus(8'h08, 12'd40, 12'd64, 12'd1);
        cyc = 0;
        while (!burst_finish && cyc < 2000) begin
            @(negedge mem_clk);
            #2;
            cyc++;
        end
        checkOutput("abort drain ends", 64'(cyc < 2000), 64'd1);
        @(negedge mem_clk);
        #1;
        checkOutput("abort flushed valid", 64'(vout_valid), 64'd0);
        checkOutput("abort frame_busy", 64'(frame_busy), 64'd1);
        checkOutput("abort no new burst yet", 64'(bursts_seen), 64'd0);
        ready_mode = 1;
        waitDone("abort done", 20000);
        checkOutput("abort bursts", 64'(bursts_seen), 64'd1);
        checkOutput("abort first addr", 64'(first_addr), 64'h014008);
        checkOutput("abort words out", 64'(words_out), 64'd64);
        repeat (3) @(negedge mem_clk);

        // Empty window: no request, busy for exactly one cycle.
        $display("[TB] zero-width sequence");
        resetCounters();
        applyStimulus(8'h00, 12'd0, 12'd0, 12'd5);
        busy_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (frame_busy) begin
                busy_cycles++;
            end
            @(negedge mem_clk);
        end
        checkOutput("zero width busy cycles", 64'(busy_cycles), 64'd1);
        checkOutput("zero width bursts", 64'(bursts_seen), 64'd0);
        checkOutput("zero width valid", 64'(vout_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
